ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port 1K x 16 program/data RAM among NUM_REQ requesters: CPU control unit, ROM loader, debug/IO DMA.
- Round-robin arbitration with registered one-hot grants.
- Optional locked bursts, bounded by a hold counter.
- Sits between the requesters and the RAM. Muxes the granted requester's address, data and write enable onto the RAM port, and returns per-requester read-valid strobes.

Parameters:
NUM_REQ, 3, number of requesters (index 0 = CPU, 1 = loader, 2 = DMA); range 2..8
ADDR_W, 10, RAM address width
DATA_W, 16, RAM data width
MAX_HOLD, 8, maximum consecutive granted cycles per ownership; must be >= 1

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req  input  NUM_REQ  per-requester access request, level
lock  input  NUM_REQ  per-requester burst-lock; sampled only for the current owner
we  input  NUM_REQ  per-requester write enable (0 = read)
addr  input  NUM_REQ*ADDR_W  flattened addresses; slice i = addr[i*ADDR_W +: ADDR_W]
wdata  input  NUM_REQ*DATA_W  flattened write data, same slicing
gnt  output  NUM_REQ  registered one-hot grant (all-zero when idle)
ram_addr  output  ADDR_W  RAM address, combinational mux of the owner's slice
ram_din  output  DATA_W  RAM write data, owner's slice
ram_write  output  1  RAM write strobe
rd_valid  output  NUM_REQ  registered; bit i high the cycle RAM read data for owner i is on ram_dout

Behaviour:
- Reset: state = IDLE, gnt = 0, rd_valid = 0, hold_cnt = 0, rr_ptr = 0.
- With gnt = 0: ram_addr = 0, ram_din = 0, ram_write = 0.
- State machine:
  - IDLE: if any req, arbitrate and load gnt next edge → GRANT; else stay.
  - GRANT: one access per cycle for owner o (gnt[o] = 1). Access valid iff req[o] = 1.
- Mux and write strobe: ram_addr = addr[o], ram_din = wdata[o], ram_write = gnt[o] & req[o] & we[o].
- Dropped request: if req[o] = 0 in a GRANT cycle, no access occurs (no write, no rd_valid).
- Extend vs. release at end of each GRANT cycle:
  - Extend (same owner, hold_cnt + 1) iff req[o] & lock[o] & (hold_cnt < MAX_HOLD-1).
  - Otherwise release: hold_cnt ← 0, rr_ptr ← (o+1) mod NUM_REQ, and re-arbitrate the same edge.
  - If any req is pending, load the new gnt → GRANT (no idle bubble). Else gnt ← 0 → IDLE.
- Unlocked access = single beat; the owner releases after one cycle.
- Arbitration: the first set bit of req searching from rr_ptr upward, wrapping. A former owner is eligible again, but only after all others in rotation order.
- Forced release: when hold_cnt reaches MAX_HOLD-1 the owner is released even if lock is held. It re-competes normally.
- With MAX_HOLD = 1, lock has no effect.
- Read latency:
  - rd_valid[o] ← gnt[o] & req[o] & ~we[o], registered; all other bits 0.
  - Requesters capture shared ram_dout when their rd_valid bit is high.
- Requester inputs may change while not granted without effect; only the owner's slices reach the RAM.
- Async reset mid-burst:
  - gnt, rd_valid and ram_write drop immediately (combinational gating from gnt).
  - Any write in that cycle is aborted; the pointer returns to 0.
- gnt is never multi-hot; assert this.

Test Plan:
- Single read: req = 001, we = 0, addr0 = 0x155 from IDLE → gnt = 001 next cycle, ram_addr = 0x155, ram_write = 0; rd_valid = 001 the following cycle; then gnt = 000.
- Round-robin: req = 111 held unlocked from reset → gnt sequence 001, 010, 100, 001, one cycle each, no idle cycles.
- Locked burst with forced release: MAX_HOLD = 8; req = 011, lock[0] = 1 held → gnt = 001 for exactly 8 cycles, then 010 for 1 cycle, then 001 again.
- Write gating: owner 2 granted, we[2] = 1, wdata2 = 0xBEEF, addr2 = 0x3FF → ram_write = 1, ram_din = 0xBEEF for one cycle. Same with req[2] deasserted in the grant cycle → ram_write = 0.
- Reset mid-burst: assert rst during the 4th locked cycle of owner 1 → gnt = 000, ram_write = 0, rd_valid = 000 immediately. After rst release with req = 110 → first gnt = 010 (pointer reset to 0).
- Idle return: single request serviced, then req = 000 → gnt = 000 and state IDLE. A new req[1] → gnt = 010 exactly one cycle later.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side signals of the shared program/data RAM port.
// Requester fields are flattened: slice i belongs to requester i.
interface ram_port_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [ADDR_W-1:0]         ram_addr;
  logic [DATA_W-1:0]         ram_din;
  logic                      ram_write;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rd_valid, ram_addr, ram_din, ram_write
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rd_valid, ram_addr, ram_din, ram_write
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ requesters,
// with registered one-hot grants and lock-extended bursts capped at MAX_HOLD.
module ram_port_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  ram_port_arbiter_if.slave bus
);
  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_next;
  logic [NUM_REQ-1:0] gnt, gnt_next;
  logic [NUM_REQ-1:0] rd_valid, rd_valid_next;
  logic [HOLD_W-1:0]  hold_cnt, hold_next;
  logic [PTR_W-1:0]   rr_ptr, ptr_next, owner, owner_succ;
  logic               extend;

  // First requester at or after 'start', wrapping; the descending scan leaves
  // the lowest rotation distance as the final assignment.
  function automatic logic [NUM_REQ-1:0] pick(input logic [NUM_REQ-1:0] r,
                                               input logic [PTR_W-1:0]   start);
    logic [NUM_REQ-1:0] sel;
    int                 idx;
    sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NUM_REQ;
      if (r[idx]) begin
        sel      = '0;
        sel[idx] = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) owner = PTR_W'(i);
    end
  end

  assign owner_succ = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;

  // Everything reaching the RAM is gated by the registered grant, so an async
  // reset aborts an in-flight write without waiting for a clock edge.
  always_comb begin
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        bus.ram_addr = bus.addr[i*ADDR_W +: ADDR_W];
        bus.ram_din  = bus.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.ram_write = |(gnt & bus.req & bus.we);
  assign bus.gnt       = gnt;
  assign bus.rd_valid  = rd_valid;

  assign extend = (|(gnt & bus.req & bus.lock)) && (int'(hold_cnt) < MAX_HOLD - 1);

  always_comb begin
    state_next    = state;
    gnt_next      = gnt;
    hold_next     = hold_cnt;
    ptr_next      = rr_ptr;
    rd_valid_next = gnt & bus.req & ~bus.we;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          gnt_next   = pick(bus.req, rr_ptr);
          hold_next  = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (extend) begin
          hold_next = hold_cnt + 1'b1;
        end else begin
          // Release and re-arbitrate on the same edge to avoid an idle bubble.
          hold_next = '0;
          ptr_next  = owner_succ;
          if (|bus.req) begin
            gnt_next = pick(bus.req, owner_succ);
          end else begin
            gnt_next   = '0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        gnt_next   = '0;
        hold_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      rd_valid <= '0;
      hold_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_next;
      gnt      <= gnt_next;
      rd_valid <= rd_valid_next;
      hold_cnt <= hold_next;
      rr_ptr   <= ptr_next;
    end
  end

  gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised scoreboard bench for ram_port_arbiter: a rule-level model predicts
// grants, RAM accesses and read strobes; two monitors compare them.
module tb_ram_port_arbiter;
  localparam int N  = 3;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int MH = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          wr;
  } acc_t;

  typedef struct {
    logic [N-1:0] gnt;
    logic [N-1:0] rd;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ram_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  acc_t acc_q[$];
  out_t out_q[$];

  // Reference model: current owner (-1 when idle), cycles held, rotation pointer.
  int m_owner = -1;
  int m_hold  = 0;
  int m_ptr   = 0;

  logic [N-1:0] rr_seq [4];
  logic [N-1:0] burst_seq [10];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic apply_stimulus(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] w,
                                input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    acc_t ae;
    out_t oe;
    int   o;
    @(negedge clk);
    bus.req   = r;
    bus.lock  = l;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    o     = m_owner;
    oe.rd = '0;
    if (o >= 0) begin
      ae.addr = a[o*AW +: AW];
      ae.din  = d[o*DW +: DW];
      ae.wr   = r[o] & w[o];
      acc_q.push_back(ae);
      if (r[o] && !w[o]) oe.rd[o] = 1'b1;
    end
    if (o < 0) begin
      m_owner = first_from(r, m_ptr);
      m_hold  = 0;
    end else if (r[o] && l[o] && m_hold < MH - 1) begin
      m_hold++;
    end else begin
      m_hold  = 0;
      m_ptr   = (o + 1) % N;
      m_owner = first_from(r, m_ptr);
    end
    oe.gnt = '0;
    if (m_owner >= 0) oe.gnt[m_owner] = 1'b1;
    out_q.push_back(oe);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.req   = '0;
    bus.lock  = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    acc_q.delete();
    out_q.delete();
    m_owner = -1;
    m_hold  = 0;
    m_ptr   = 0;
    #1;
    check_output("rst_gnt", 32'(bus.gnt), 32'd0);
    check_output("rst_ram_write", 32'(bus.ram_write), 32'd0);
    check_output("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Grant / read-strobe monitor, sampled just after each rising edge.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && out_q.size() > 0) begin
        e = out_q.pop_front();
        check_output("gnt", 32'(bus.gnt), 32'(e.gnt));
        check_output("rd_valid", 32'(bus.rd_valid), 32'(e.rd));
      end
    end
  end

  // RAM-port monitor, sampled mid-cycle once the stimulus has settled.
  initial begin
    acc_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.gnt != '0) begin
        if (acc_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL ram_access unexpected gnt=0x%0h expected no owner at t=%0t", bus.gnt, $time);
        end else begin
          e = acc_q.pop_front();
          check_output("ram_addr", 32'(bus.ram_addr), 32'(e.addr));
          check_output("ram_din", 32'(bus.ram_din), 32'(e.din));
          check_output("ram_write", 32'(bus.ram_write), 32'(e.wr));
        end
      end else begin
        check_output("idle_ram_addr", 32'(bus.ram_addr), 32'd0);
        check_output("idle_ram_din", 32'(bus.ram_din), 32'd0);
        check_output("idle_ram_write", 32'(bus.ram_write), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    logic [N-1:0]    r, l, w;

    rr_seq    = '{3'b001, 3'b010, 3'b100, 3'b001};
    burst_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
                  3'b001, 3'b001, 3'b001, 3'b010, 3'b001};

    do_reset();

    // Single read from idle.
    a = '0;
    a[AW-1:0] = 10'h155;
    apply_stimulus(3'b001, 3'b000, 3'b000, a, '0);
    @(posedge clk); #1;
    check_output("read_gnt", 32'(bus.gnt), 32'h1);
    check_output("read_addr", 32'(bus.ram_addr), 32'h155);
    check_output("read_write", 32'(bus.ram_write), 32'h0);
    apply_stimulus(3'b001, 3'b000, 3'b000, a, '0);
    @(posedge clk); #1;
    check_output("read_rd_valid", 32'(bus.rd_valid), 32'h1);
    repeat (2) apply_stimulus('0, '0, '0, '0, '0);

    // Unlocked round robin from reset.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(3'b111, 3'b000, 3'b000, '0, '0);
      @(posedge clk); #1;
      check_output("rr_gnt", 32'(bus.gnt), 32'(rr_seq[k]));
    end

    // Locked burst capped at MAX_HOLD cycles.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(3'b011, 3'b001, 3'b000, '0, '0);
      @(posedge clk); #1;
      check_output("burst_gnt", 32'(bus.gnt), 32'(burst_seq[k]));
    end

    // Write gating for owner 2.
    do_reset();
    a = '0; a[2*AW +: AW] = 10'h3FF;
    d = '0; d[2*DW +: DW] = 16'hBEEF;
    apply_stimulus(3'b100, 3'b000, 3'b100, a, d);
    @(posedge clk); #1;
    check_output("wr_gnt", 32'(bus.gnt), 32'h4);
    apply_stimulus(3'b100, 3'b000, 3'b100, a, d);
    #1;
    check_output("wr_strobe", 32'(bus.ram_write), 32'h1);
    check_output("wr_din", 32'(bus.ram_din), 32'hBEEF);
    check_output("wr_addr", 32'(bus.ram_addr), 32'h3FF);
    apply_stimulus(3'b000, 3'b000, 3'b100, a, d);
    #1;
    check_output("wr_dropped", 32'(bus.ram_write), 32'h0);
    apply_stimulus('0, '0, '0, '0, '0);

    // Reset in the 4th locked write cycle of owner 1.
    do_reset();
    a = '0; a[AW +: AW] = 10'h2A5;
    d = '0; d[DW +: DW] = 16'h1234;
    for (int k = 0; k < 5; k++) apply_stimulus(3'b010, 3'b010, 3'b010, a, d);
    #1;
    check_output("burst_pre_rst_write", 32'(bus.ram_write), 32'h1);
    #2;
    do_reset();
    apply_stimulus(3'b110, 3'b000, 3'b000, '0, '0);
    @(posedge clk); #1;
    check_output("post_rst_gnt", 32'(bus.gnt), 32'h2);

    // Return to idle, then a fresh request is granted one cycle later.
    apply_stimulus('0, '0, '0, '0, '0);
    apply_stimulus('0, '0, '0, '0, '0);
    @(posedge clk); #1;
    check_output("idle_gnt", 32'(bus.gnt), 32'h0);
    apply_stimulus(3'b010, 3'b000, 3'b000, '0, '0);
    @(posedge clk); #1;
    check_output("wake_gnt", 32'(bus.gnt), 32'h2);
    apply_stimulus(3'b010, 3'b000, 3'b000, '0, '0);

    // Randomised traffic.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        r[i] = ($urandom_range(0, 99) < 55);
        l[i] = ($urandom_range(0, 99) < 50);
        w[i] = ($urandom_range(0, 99) < 40);
        a[i*AW +: AW] = AW'($urandom);
        d[i*DW +: DW] = DW'($urandom);
      end
      apply_stimulus(r, l, w, a, d);
    end

    repeat (3) apply_stimulus('0, '0, '0, '0, '0);
    @(posedge clk); #2;
    check_output("acc_q_drained", 32'(acc_q.size()), 32'd0);
    check_output("out_q_drained", 32'(out_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
